// File: rtl/if_id_hazard_ctrl.sv
// IF/ID pipeline sequencer: chooses advance, stall, flush or freeze each cycle and
// drives PC/IF-ID enables plus an ID/EX bubble, with saturating stall/flush counters.
module if_id_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] S_RUN        = 2'd0;
  localparam logic [1:0] S_MEM_WAIT   = 2'd1;
  localparam logic [1:0] S_FLUSH      = 2'd2;
  localparam logic [1:0] S_LOAD_STALL = 2'd3;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] LOAD_RELOAD  = 3'(LOAD_STALL_CYCLES - 1);

  logic [1:0]       r_state;
  logic [2:0]       r_cnt;
  logic             r_br_pend;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [1:0] w_state_next;
  logic [2:0] w_cnt_next;
  logic       w_pend_next;
  logic       w_flush_inc;
  logic       w_run_eval;
  logic       w_pc_we;
  logic       w_if_id_we;
  logic       w_flush;
  logic       w_bubble;
  logic       w_mem_busy;
  logic       w_load_use;
  logic       w_br;

  assign w_mem_busy = !imem_ready || !dmem_ready;
  assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));
  // A branch that arrived while frozen is replayed from the pending bit.
  assign w_br = branch_taken || r_br_pend;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pend_next  = r_br_pend;
    w_flush_inc  = 1'b0;
    w_run_eval   = 1'b0;
    w_pc_we      = 1'b0;
    w_if_id_we   = 1'b0;
    w_flush      = 1'b0;
    w_bubble     = 1'b0;

    case (r_state)
      S_FLUSH: begin
        if (w_mem_busy) begin
          w_pend_next = w_br;
        end else begin
          w_pc_we     = 1'b1;
          w_flush     = 1'b1;
          w_bubble    = 1'b1;
          w_pend_next = 1'b0;
          if (w_br) begin
            w_cnt_next  = FLUSH_RELOAD;
            w_flush_inc = 1'b1;
          end else if (r_cnt == 3'd1) begin
            w_state_next = S_RUN;
          end else begin
            w_cnt_next = r_cnt - 3'd1;
          end
        end
      end
      S_LOAD_STALL: begin
        if (w_mem_busy) begin
          w_pend_next = w_br;
        end else if (w_br) begin
          w_run_eval = 1'b1;
        end else begin
          w_bubble = 1'b1;
          if (r_cnt == 3'd1) w_state_next = S_RUN;
          else               w_cnt_next   = r_cnt - 3'd1;
        end
      end
      default: w_run_eval = 1'b1;
    endcase

    // MEM_WAIT shares the RUN decision so leaving it costs no dead cycle.
    if (w_run_eval) begin
      if (w_mem_busy) begin
        w_pend_next  = w_br;
        w_state_next = S_MEM_WAIT;
      end else if (w_br) begin
        w_pc_we      = 1'b1;
        w_flush      = 1'b1;
        w_bubble     = 1'b1;
        w_pend_next  = 1'b0;
        w_flush_inc  = 1'b1;
        w_cnt_next   = FLUSH_RELOAD;
        w_state_next = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
      end else if (w_load_use) begin
        w_bubble     = 1'b1;
        w_cnt_next   = LOAD_RELOAD;
        w_state_next = (LOAD_STALL_CYCLES > 1) ? S_LOAD_STALL : S_RUN;
      end else begin
        w_pc_we      = 1'b1;
        w_if_id_we   = 1'b1;
        w_state_next = S_RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_cnt       <= 3'd0;
      r_br_pend   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_br_pend <= w_pend_next;
      if (!w_pc_we && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign pc_we        = !reset && w_pc_we;
  assign if_id_we     = !reset && w_if_id_we;
  assign if_id_flush  = reset || w_flush;
  assign id_ex_bubble = reset || w_bubble;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Directed bench for if_id_hazard_ctrl: two instances (short/long stall, narrow counters)
// checked against a queue of hand-derived per-cycle expectations.
module tb_if_id_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] id_rs1 = 5'd0;
  logic [4:0] id_rs2 = 5'd7;
  logic id_uses_rs1 = 1'b0;
  logic id_uses_rs2 = 1'b0;
  logic [4:0] ex_rd = 5'd0;
  logic ex_mem_read = 1'b0;
  logic branch_taken = 1'b0;
  logic imem_ready = 1'b1;
  logic dmem_ready = 1'b1;

  logic pc_we_a, if_id_we_a, if_id_flush_a, id_ex_bubble_a;
  logic pc_we_b, if_id_we_b, if_id_flush_b, id_ex_bubble_b;
  logic [15:0] stall_cnt_a, flush_cnt_a;
  logic [3:0]  stall_cnt_b, flush_cnt_b;

  int checks = 0;
  int errors = 0;
  int es_a = 0;
  int es_b = 0;

  // Expected {pc_we, if_id_we, if_id_flush, id_ex_bubble}
  localparam logic [3:0] RUNV = 4'b1100;
  localparam logic [3:0] STL  = 4'b0001;
  localparam logic [3:0] FLS  = 4'b1011;
  localparam logic [3:0] FRZ  = 4'b0000;
  localparam logic [3:0] RST  = 4'b0011;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       cb;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  if_id_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_we(pc_we_a), .if_id_we(if_id_we_a), .if_id_flush(if_id_flush_a),
    .id_ex_bubble(id_ex_bubble_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  if_id_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(1), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_we(pc_we_b), .if_id_we(if_id_we_b), .if_id_flush(if_id_flush_b),
    .id_ex_bubble(id_ex_bubble_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  task automatic step(input logic rst, input logic [4:0] rs1, input logic us1,
                      input logic us2, input logic [4:0] rd, input logic mr,
                      input logic br, input logic im, input logic dm,
                      input logic [3:0] ea, input logic [3:0] eb, input logic cb,
                      input string tag);
    exp_t e;
    logic [3:0] ga, gb;
    @(negedge clk);
    reset = rst; id_rs1 = rs1; id_uses_rs1 = us1; id_uses_rs2 = us2;
    ex_rd = rd; ex_mem_read = mr; branch_taken = br;
    imem_ready = im; dmem_ready = dm;
    e.a = ea; e.b = eb; e.cb = cb;
    q.push_back(e);
    if (rst) begin
      es_a = 0; es_b = 0;
    end else begin
      if (!ea[3]) es_a++;
      if (!eb[3] && es_b != 15) es_b++;
    end
    #1;
    e = q.pop_front();
    ga = {pc_we_a, if_id_we_a, if_id_flush_a, id_ex_bubble_a};
    checks++;
    assert (ga === e.a) else begin
      errors++;
      $error("FAIL %s dut_a ctrl: observed %b expected %b", tag, ga, e.a);
    end
    if (e.cb) begin
      gb = {pc_we_b, if_id_we_b, if_id_flush_b, id_ex_bubble_b};
      checks++;
      assert (gb === e.b) else begin
        errors++;
        $error("FAIL %s dut_b ctrl: observed %b expected %b", tag, gb, e.b);
      end
    end
  endtask

  task automatic chk_cnts(input int fa, input int fb, input logic cb, input string tag);
    @(posedge clk);
    #1;
    checks++;
    assert (32'(stall_cnt_a) === es_a) else begin
      errors++;
      $error("FAIL %s stall_cnt_a: observed %0d expected %0d", tag, stall_cnt_a, es_a);
    end
    checks++;
    assert (32'(flush_cnt_a) === fa) else begin
      errors++;
      $error("FAIL %s flush_cnt_a: observed %0d expected %0d", tag, flush_cnt_a, fa);
    end
    if (cb) begin
      checks++;
      assert (32'(stall_cnt_b) === es_b) else begin
        errors++;
        $error("FAIL %s stall_cnt_b: observed %0d expected %0d", tag, stall_cnt_b, es_b);
      end
      checks++;
      assert (32'(flush_cnt_b) === fb) else begin
        errors++;
        $error("FAIL %s flush_cnt_b: observed %0d expected %0d", tag, flush_cnt_b, fb);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, RST, RST, 1, "reset_outputs");
    chk_cnts(0, 0, 1, "reset_counters");

    // Normal flow
    for (int i = 0; i < 20; i++)
      step(0, 0, 0, 0, 0, 0, 0, 1, 1, RUNV, RUNV, 0, "normal");
    chk_cnts(0, 0, 0, "normal_counters");

    // Load-use via rs1 and rs2, then non-hazards (x0 target, non-load)
    step(0, 5, 1, 0, 5, 1, 0, 1, 1, STL, RUNV, 0, "load_use_rs1");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, RUNV, RUNV, 0, "after_load_use_rs1");
    step(0, 0, 0, 1, 7, 1, 0, 1, 1, STL, RUNV, 0, "load_use_rs2");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, RUNV, RUNV, 0, "after_load_use_rs2");
    step(0, 0, 1, 0, 0, 1, 0, 1, 1, RUNV, RUNV, 0, "load_x0_no_hazard");
    step(0, 5, 1, 0, 5, 0, 0, 1, 1, RUNV, RUNV, 0, "non_load_no_hazard");
    chk_cnts(0, 0, 0, "load_use_counters");

    // Taken branch: two flush cycles
    step(0, 0, 0, 0, 0, 0, 1, 1, 1, FLS, RUNV, 0, "branch_c1");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, FLS, RUNV, 0, "branch_c2");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, RUNV, RUNV, 0, "branch_done");
    chk_cnts(1, 0, 0, "branch_counters");

    // Branch and load-use together: branch wins
    step(0, 5, 1, 0, 5, 1, 1, 1, 1, FLS, RUNV, 0, "br_lu_c1");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, FLS, RUNV, 0, "br_lu_c2");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, RUNV, RUNV, 0, "br_lu_done");
    chk_cnts(2, 0, 0, "br_lu_counters");

    // dmem wait 3 cycles, branch in the 2nd is replayed after the wait
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, RUNV, 0, "dmem_wait_1");
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ, RUNV, 0, "dmem_wait_2_br");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, RUNV, 0, "dmem_wait_3");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, FLS, RUNV, 0, "pending_br_c1");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, FLS, RUNV, 0, "pending_br_c2");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, RUNV, RUNV, 0, "pending_br_done");
    chk_cnts(3, 0, 0, "mem_wait_counters");

    // Branch during FLUSH reloads; imem busy during FLUSH holds
    step(0, 0, 0, 0, 0, 0, 1, 1, 1, FLS, RUNV, 0, "rebranch_c1");
    step(0, 0, 0, 0, 0, 0, 1, 1, 1, FLS, RUNV, 0, "rebranch_c2");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, FLS, RUNV, 0, "rebranch_c3");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, RUNV, RUNV, 0, "rebranch_done");
    step(0, 0, 0, 0, 0, 0, 1, 1, 1, FLS, RUNV, 0, "flush_busy_c1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, FRZ, RUNV, 0, "flush_busy_frz");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, FLS, RUNV, 0, "flush_busy_c2");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, RUNV, RUNV, 0, "flush_busy_done");
    chk_cnts(6, 0, 0, "flush_counters");

    // Long load stall on dut_b, reset mid-stall
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, RST, RST, 1, "reset2");
    chk_cnts(0, 0, 1, "reset2_counters");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, RUNV, RUNV, 1, "b_run");
    step(0, 5, 1, 0, 5, 1, 0, 1, 1, STL, STL, 1, "b_lu_c1");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, RUNV, STL, 1, "b_lu_c2");
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, RST, RST, 1, "reset_mid_stall");
    chk_cnts(0, 0, 1, "reset_mid_stall_counters");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, RUNV, RUNV, 1, "run_after_reset");

    // Branch aborts dut_b's load stall
    step(0, 5, 1, 0, 5, 1, 0, 1, 1, STL, STL, 1, "abort_lu");
    step(0, 0, 0, 0, 0, 0, 1, 1, 1, FLS, FLS, 1, "abort_br");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, FLS, RUNV, 1, "abort_after1");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, RUNV, RUNV, 1, "abort_after2");
    chk_cnts(1, 1, 1, "abort_counters");

    // Saturation of the 4-bit stall counter
    for (int i = 0; i < 21; i++)
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, FRZ, 1, "saturate_frz");
    chk_cnts(1, 1, 1, "saturate_counters");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, RUNV, RUNV, 1, "saturate_resume");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
